// File: rtl/snake_core.sv
// Single-snake engine: direction-chain body storage, per-frame head-to-tail replay, run-state FSM.
// Optional build macro SNAKE_CORE_WRAP_EN: the head wraps around the field edges instead of dying.
module snake_core #(
   parameter int GRID_W  = 20,
   parameter int GRID_H  = 12,
   parameter int MAX_LEN = 64,
   parameter int X_W     = $clog2(GRID_W + 2),
   parameter int Y_W     = $clog2(GRID_H + 2),
   parameter int L_W     = $clog2(MAX_LEN)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_start,
   input  logic           i_tick,
   input  logic [1:0]     i_dir,
   input  logic           i_eat,
   output logic [1:0]     o_state,
   output logic [X_W-1:0] o_head_x,
   output logic [Y_W-1:0] o_head_y,
   output logic [1:0]     o_head_dir,
   output logic [L_W-1:0] o_length,
   output logic [X_W-1:0] o_pos_x,
   output logic [Y_W-1:0] o_pos_y,
   output logic           o_pos_first,
   output logic           o_pos_last,
   output logic           o_pos_valid,
   output logic           o_failure,
   output logic           o_success
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDead = 2'b10,
      StWon  = 2'b11
   } state_t;

   localparam logic [X_W-1:0] HOME_X   = X_W'(GRID_W / 2);
   localparam logic [Y_W-1:0] HOME_Y   = Y_W'(GRID_H / 2);
   localparam logic [L_W-1:0] LAST_POS = L_W'(MAX_LEN - 1);

   function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input logic [1:0] d);
      logic [X_W-1:0] n;
      n = x;
`ifdef SNAKE_CORE_WRAP_EN
      if (d == 2'b10)      n = (x == X_W'(GRID_W)) ? X_W'(1) : x + 1'b1;
      else if (d == 2'b11) n = (x == X_W'(1)) ? X_W'(GRID_W) : x - 1'b1;
`else
      if (d == 2'b10)      n = x + 1'b1;
      else if (d == 2'b11) n = x - 1'b1;
`endif
      return n;
   endfunction

   function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input logic [1:0] d);
      logic [Y_W-1:0] n;
      n = y;
`ifdef SNAKE_CORE_WRAP_EN
      if (d == 2'b00)      n = (y == Y_W'(GRID_H)) ? Y_W'(1) : y + 1'b1;
      else if (d == 2'b01) n = (y == Y_W'(1)) ? Y_W'(GRID_H) : y - 1'b1;
`else
      if (d == 2'b00)      n = y + 1'b1;
      else if (d == 2'b01) n = y - 1'b1;
`endif
      return n;
   endfunction

   state_t         r_state;
   logic [X_W-1:0] r_head_x;
   logic [Y_W-1:0] r_head_y;
   logic [1:0]     r_head_dir;
   logic [L_W-1:0] r_length;
   logic [L_W-1:0] r_pos;
   logic [X_W-1:0] r_seg_x;
   logic [Y_W-1:0] r_seg_y;
   logic           r_tick_pend;
   logic [1:0]     r_dirs [MAX_LEN];

   logic           w_run;
   logic           w_slot;
   logic           w_start;
   logic           w_commit;
   logic [1:0]     w_new_dir;
   logic [X_W-1:0] w_step_x;
   logic [Y_W-1:0] w_step_y;
   logic [X_W-1:0] w_head_nxt_x;
   logic [Y_W-1:0] w_head_nxt_y;
   logic [1:0]     w_replay_dir;
   logic           w_pos_valid;
   logic           w_hit;
   logic           w_wall;
   logic           w_win;

   assign w_run     = (r_state == StRun);
   assign w_slot    = (r_pos == LAST_POS);
   assign w_start   = i_start && !w_run;
   assign w_commit  = w_run && w_slot && (r_tick_pend || i_tick);
   // A request for the exact opposite of the current heading is dropped.
   assign w_new_dir = (i_dir == (r_head_dir ^ 2'b01)) ? r_head_dir : i_dir;
   assign w_step_x  = step_x(r_head_x, w_new_dir);
   assign w_step_y  = step_y(r_head_y, w_new_dir);

   assign w_head_nxt_x = w_start ? HOME_X : (w_commit ? w_step_x : r_head_x);
   assign w_head_nxt_y = w_start ? HOME_Y : (w_commit ? w_step_y : r_head_y);

   // Segment k+1 sits one cell behind segment k, against the direction segment k moved in.
   assign w_replay_dir = r_dirs[r_pos] ^ 2'b01;
   assign w_pos_valid  = (r_pos < r_length);
   assign w_hit        = w_pos_valid && (r_pos != '0) &&
                         (r_seg_x == r_head_x) && (r_seg_y == r_head_y);
   assign w_win        = (r_length == LAST_POS);

`ifdef SNAKE_CORE_WRAP_EN
   assign w_wall = 1'b0;
`else
   assign w_wall = (r_head_x == '0) || (r_head_x == X_W'(GRID_W + 1)) ||
                   (r_head_y == '0) || (r_head_y == Y_W'(GRID_H + 1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_head_x    <= HOME_X;
         r_head_y    <= HOME_Y;
         r_head_dir  <= 2'b00;
         r_length    <= L_W'(1);
         r_pos       <= LAST_POS;
         r_seg_x     <= HOME_X;
         r_seg_y     <= HOME_Y;
         r_tick_pend <= 1'b0;
      end else begin
         r_pos <= w_slot ? '0 : r_pos + 1'b1;
         if (w_slot) begin
            r_seg_x <= w_head_nxt_x;
            r_seg_y <= w_head_nxt_y;
         end else begin
            r_seg_x <= step_x(r_seg_x, w_replay_dir);
            r_seg_y <= step_y(r_seg_y, w_replay_dir);
         end

         case (r_state)
            StRun: begin
               if (i_tick) r_tick_pend <= 1'b1;
               if (w_slot) r_tick_pend <= 1'b0;
               if (w_commit) begin
                  r_head_x   <= w_step_x;
                  r_head_y   <= w_step_y;
                  r_head_dir <= w_new_dir;
               end
               if (i_eat && !w_win) r_length <= r_length + 1'b1;
               if (w_win)                r_state <= StWon;
               else if (w_hit || w_wall) r_state <= StDead;
            end
            default: begin
               if (i_start) begin
                  r_state     <= StRun;
                  r_head_x    <= HOME_X;
                  r_head_y    <= HOME_Y;
                  r_head_dir  <= 2'b00;
                  r_length    <= L_W'(1);
                  r_tick_pend <= 1'b0;
               end
            end
         endcase
      end
   end

   // Body storage carries no reset; only entries below the length are ever trusted.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int i = MAX_LEN - 1; i > 0; i--) r_dirs[i] <= r_dirs[i-1];
         r_dirs[0] <= w_new_dir;
      end
   end

   assign o_state     = r_state;
   assign o_head_x    = r_head_x;
   assign o_head_y    = r_head_y;
   assign o_head_dir  = r_head_dir;
   assign o_length    = r_length;
   assign o_pos_x     = r_seg_x;
   assign o_pos_y     = r_seg_y;
   assign o_pos_first = (r_pos == '0);
   assign o_pos_last  = (r_pos == r_length - 1'b1);
   assign o_pos_valid = w_pos_valid;
   assign o_failure   = (r_state == StDead);
   assign o_success   = (r_state == StWon);

endmodule

// File: tb/tb_snake_core.sv
// Directed bench for snake_core: table of moves with hand-computed head/length, plus corner sequences.
module tb_snake_core;

   localparam int GRID_W  = 20;
   localparam int GRID_H  = 12;
   localparam int MAX_LEN = 64;
   localparam int X_W     = $clog2(GRID_W + 2);
   localparam int Y_W     = $clog2(GRID_H + 2);
   localparam int L_W     = $clog2(MAX_LEN);

   logic           clk = 1'b0;
   logic           rst;
   logic           i_start = 1'b0;
   logic           i_tick  = 1'b0;
   logic [1:0]     i_dir   = 2'b00;
   logic           i_eat   = 1'b0;
   logic [1:0]     o_state;
   logic [X_W-1:0] o_head_x;
   logic [Y_W-1:0] o_head_y;
   logic [1:0]     o_head_dir;
   logic [L_W-1:0] o_length;
   logic [X_W-1:0] o_pos_x;
   logic [Y_W-1:0] o_pos_y;
   logic           o_pos_first;
   logic           o_pos_last;
   logic           o_pos_valid;
   logic           o_failure;
   logic           o_success;

   int errors = 0;
   int checks = 0;
   int m_pos;

   snake_core #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .MAX_LEN(MAX_LEN),
      .X_W    (X_W),
      .Y_W    (Y_W),
      .L_W    (L_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_tick     (i_tick),
      .i_dir      (i_dir),
      .i_eat      (i_eat),
      .o_state    (o_state),
      .o_head_x   (o_head_x),
      .o_head_y   (o_head_y),
      .o_head_dir (o_head_dir),
      .o_length   (o_length),
      .o_pos_x    (o_pos_x),
      .o_pos_y    (o_pos_y),
      .o_pos_first(o_pos_first),
      .o_pos_last (o_pos_last),
      .o_pos_valid(o_pos_valid),
      .o_failure  (o_failure),
      .o_success  (o_success)
   );

   always #5 clk = ~clk;

   // Independent frame-position reference: MAX_LEN-1 in reset, then free-running.
   always @(posedge clk or posedge rst) begin
      if (rst) m_pos <= MAX_LEN - 1;
      else     m_pos <= (m_pos == MAX_LEN - 1) ? 0 : m_pos + 1;
   end

   typedef struct {
      logic [1:0] dir;
      int         eats;
      int         hx;
      int         hy;
      int         hd;
      int         len;
   } move_t;

   move_t moves [7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance at least one cycle, then up to a bounded number until the frame reaches p.
   task automatic wait_pos(input int p);
      int n;
      n = 0;
      @(negedge clk);
      while (m_pos != p && n < 3 * MAX_LEN) begin
         @(negedge clk);
         n++;
      end
      chk("wait_pos", m_pos, p);
   endtask

   task automatic pulse_tick();
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
   endtask

   // Eat pulses and one tick early in a frame, then stop at the next pos 0 where the move shows.
   task automatic do_move(input logic [1:0] d, input int eats);
      wait_pos(1);
      i_dir = d;
      for (int e = 0; e < eats; e++) begin
         i_eat = 1'b1;
         @(negedge clk);
         i_eat = 1'b0;
      end
      pulse_tick();
      wait_pos(0);
   endtask

   task automatic chk_head(input string tag, input int hx, input int hy);
      chk({tag, "_head_x"}, int'(o_head_x), hx);
      chk({tag, "_head_y"}, int'(o_head_y), hy);
   endtask

   initial begin
      moves[0] = '{dir: 2'b11, eats: 0, hx: 12, hy: 6, hd: 2, len: 1};
      moves[1] = '{dir: 2'b10, eats: 3, hx: 13, hy: 6, hd: 2, len: 4};
      moves[2] = '{dir: 2'b10, eats: 0, hx: 14, hy: 6, hd: 2, len: 4};
      moves[3] = '{dir: 2'b10, eats: 1, hx: 15, hy: 6, hd: 2, len: 5};
      moves[4] = '{dir: 2'b00, eats: 0, hx: 15, hy: 7, hd: 0, len: 5};
      moves[5] = '{dir: 2'b11, eats: 0, hx: 14, hy: 7, hd: 3, len: 5};
      moves[6] = '{dir: 2'b01, eats: 0, hx: 14, hy: 6, hd: 1, len: 5};

      // Reset state
      rst = 1'b1;
      #12;
      chk("rst_state", int'(o_state), 0);
      chk_head("rst", 10, 6);
      chk("rst_dir", int'(o_head_dir), 0);
      chk("rst_len", int'(o_length), 1);
      chk("rst_valid", int'(o_pos_valid), 0);
      chk("rst_failure", int'(o_failure), 0);
      @(negedge clk);
      rst = 1'b0;

      // Two idle frames: only pos 0 is a real segment, and it is the head
      for (int c = 0; c < 2 * MAX_LEN; c++) begin
         @(negedge clk);
         chk("idle_valid", int'(o_pos_valid), int'(m_pos == 0));
         chk("idle_first", int'(o_pos_first), int'(m_pos == 0));
         chk("idle_last", int'(o_pos_last), int'(m_pos == 0));
         if (m_pos == 0) chk("idle_pos_x", int'(o_pos_x), 10);
      end
      chk("idle_state", int'(o_state), 0);
      chk_head("idle", 10, 6);

      // Start, then two ticks in one frame give a single move
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("start_state", int'(o_state), 1);
      i_dir = 2'b10;
      wait_pos(20);
      pulse_tick();
      wait_pos(40);
      pulse_tick();
      wait_pos(0);
      chk_head("move1", 11, 6);
      chk("move1_dir", int'(o_head_dir), 2);
      chk("move1_pos_x", int'(o_pos_x), 11);
      wait_pos(0);
      chk_head("no_extra", 11, 6);

      // Table: reversal rejection, growth, turns into self
      for (int i = 0; i < 7; i++) begin
         do_move(moves[i].dir, moves[i].eats);
         chk_head($sformatf("tbl%0d", i), moves[i].hx, moves[i].hy);
         chk($sformatf("tbl%0d_dir", i), int'(o_head_dir), moves[i].hd);
         chk($sformatf("tbl%0d_len", i), int'(o_length), moves[i].len);
         chk($sformatf("tbl%0d_state", i), int'(o_state), 1);
         if (i == 2) begin
            // Replay of a 4-long straight snake heading right from (14,6)
            for (int k = 0; k < 5; k++) begin
               if (k < 4) begin
                  chk($sformatf("replay%0d_x", k), int'(o_pos_x), 14 - k);
                  chk($sformatf("replay%0d_y", k), int'(o_pos_y), 6);
               end
               chk($sformatf("replay%0d_valid", k), int'(o_pos_valid), int'(k < 4));
               chk($sformatf("replay%0d_first", k), int'(o_pos_first), int'(k == 0));
               chk($sformatf("replay%0d_last", k), int'(o_pos_last), int'(k == 3));
               @(negedge clk);
            end
         end
      end

      // Segment 4 lands on the head during this frame
      wait_pos(8);
      chk("self_hit_state", int'(o_state), 2);
      chk("self_hit_failure", int'(o_failure), 1);

      // Frozen while dead: ticks and eats do nothing
      wait_pos(10);
      pulse_tick();
      i_eat = 1'b1;
      @(negedge clk);
      i_eat = 1'b0;
      wait_pos(1);
      chk_head("dead_frozen", 14, 6);
      chk("dead_len", int'(o_length), 5);

      // Restart with tick and eat on the same cycle: both dropped
      wait_pos(12);
      i_start = 1'b1;
      i_tick  = 1'b1;
      i_eat   = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_tick  = 1'b0;
      i_eat   = 1'b0;
      chk("restart_state", int'(o_state), 1);
      chk("restart_len", int'(o_length), 1);
      chk_head("restart", 10, 6);
      chk("restart_dir", int'(o_head_dir), 0);
      wait_pos(1);
      chk_head("restart_no_tick", 10, 6);
      chk("restart_no_eat", int'(o_length), 1);

      // Eleven moves right from x=10 reach the right border column
      for (int m = 0; m < 11; m++) do_move(2'b10, 0);
      wait_pos(3);
`ifdef SNAKE_CORE_WRAP_EN
      chk_head("wrap", 1, 6);
      chk("wrap_state", int'(o_state), 1);
      chk("wrap_failure", int'(o_failure), 0);
`else
      chk_head("wall", 21, 6);
      chk("wall_state", int'(o_state), 2);
      chk("wall_failure", int'(o_failure), 1);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("restart2_state", int'(o_state), 1);
`endif

      // Continuous eating saturates at MAX_LEN-1 and wins
      i_eat = 1'b1;
      repeat (MAX_LEN + 6) @(negedge clk);
      i_eat = 1'b0;
      @(negedge clk);
      chk("win_len", int'(o_length), MAX_LEN - 1);
      chk("win_state", int'(o_state), 3);
      chk("win_success", int'(o_success), 1);
      chk("win_failure", int'(o_failure), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
